// File: rtl/mult_pkg.sv
// mult_pkg
// Shared definitions for the repeated-addition multiplier family: the operand
// feeder, the multiplier itself and the result collector.
// Contents:
//   OPW, PRODW    operand and product widths
//   operand_t     one multiplier operand
//   op_pair_t     an {a, b} operand pair
//   out_state_t   feeder output-register state (EMPTY / HOLD)
package mult_pkg;

  localparam int OPW   = 4;
  localparam int PRODW = 2 * OPW;

  typedef logic [OPW-1:0] operand_t;

  typedef struct packed {
    operand_t a;
    operand_t b;
  } op_pair_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_t;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo
// Single-clock FIFO with registered occupancy count. Push is ignored when
// full and pop is ignored when empty, so the count can never overflow or
// underflow. The head entry is presented combinationally on o_rdata.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push, i_wdata   write request and data
//   i_pop, o_rdata    read request and head data
//   o_full, o_empty   occupancy flags
//   o_count           number of stored entries (0..DEPTH)
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_wdata,
  input  logic                           i_pop,
  output logic [WIDTH-1:0]               o_rdata,
  output logic                           o_full,
  output logic                           o_empty,
  output logic [$clog2(DEPTH+1)-1:0]     o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_doPush;
  logic             w_doPop;

  assign o_full   = (r_count == CW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign w_doPush = i_push && !o_full;
  assign w_doPop  = i_pop && !o_empty;
  assign o_rdata  = r_mem[r_rdPtr];
  assign o_count  = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + 1'b1;
      if (w_doPop)  r_rdPtr <= r_rdPtr + 1'b1;
      case ({w_doPush, w_doPop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage has no reset; stale entries are never visible past the pointers.
  always_ff @(posedge i_clk) begin
    if (w_doPush) r_mem[r_wrPtr] <= i_wdata;
  end

endmodule

// File: rtl/mult_operand_feeder.sv
// mult_operand_feeder
// Upstream stage of the repeated-addition multiplier. Buffers operand pairs
// from a producer in a FIFO and issues them one at a time through an output
// register. A b==0 pair is rewritten to a=0, b=1 so the multiplier finishes
// after one add step instead of waiting forever.
// Ports:
//   i_clk, i_rst              clock, synchronous active-high reset
//   i_s_valid, o_s_ready      producer handshake (ready = FIFO not full)
//   i_s_a, i_s_b              producer operands
//   o_m_valid, i_m_ready      multiplier valid_in / ready_out
//   o_m_a, o_m_b              multiplier in_a / in_b
//   o_fill_level              FIFO occupancy, output register excluded
//   o_issue_count             pairs accepted by the multiplier (wrapping)
module mult_operand_feeder #(
  parameter int OPW   = 4,
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_s_valid,
  output logic                        o_s_ready,
  input  logic [OPW-1:0]              i_s_a,
  input  logic [OPW-1:0]              i_s_b,
  output logic                        o_m_valid,
  input  logic                        i_m_ready,
  output logic [OPW-1:0]              o_m_a,
  output logic [OPW-1:0]              o_m_b,
  output logic [$clog2(DEPTH+1)-1:0]  o_fill_level,
  output logic [CNTW-1:0]             o_issue_count
);

  import mult_pkg::*;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_load;
  logic              w_transfer;
  logic [2*OPW-1:0]  w_head;
  logic [OPW-1:0]    w_headA;
  logic [OPW-1:0]    w_headB;
  out_state_t        r_state;
  out_state_t        w_nextState;
  logic [OPW-1:0]    r_mA;
  logic [OPW-1:0]    r_mB;
  logic [CNTW-1:0]   r_issueCount;

  // s_ready depends on registered FIFO state only: a full FIFO refuses a push
  // even on an edge where it also pops.
  assign o_s_ready  = !w_full;
  assign w_push     = i_s_valid && !w_full;
  assign w_transfer = (r_state == OUT_HOLD) && i_m_ready;
  assign w_load     = !w_empty && ((r_state == OUT_EMPTY) || i_m_ready);
  assign w_headA    = w_head[2*OPW-1:OPW];
  assign w_headB    = w_head[OPW-1:0];

  sync_fifo #(
    .WIDTH (2 * OPW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (w_push),
    .i_wdata ({i_s_a, i_s_b}),
    .i_pop   (w_load),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (o_fill_level)
  );

  // Output-register state.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= OUT_EMPTY;
    else       r_state <= w_nextState;
  end

  // A load always leaves the register full; a transfer without a load empties it.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      OUT_EMPTY: if (w_load) w_nextState = OUT_HOLD;
      OUT_HOLD:  if (w_transfer) w_nextState = w_load ? OUT_HOLD : OUT_EMPTY;
      default:   w_nextState = OUT_EMPTY;
    endcase
  end

  // Operand register; b==0 becomes 0*1 so the multiplier terminates.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_mA <= '0;
      r_mB <= '0;
    end else if (w_load) begin
      if (w_headB == '0) begin
        r_mA <= '0;
        r_mB <= OPW'(1);
      end else begin
        r_mA <= w_headA;
        r_mB <= w_headB;
      end
    end
  end

  // Counts handshakes accepted by the multiplier; wraps modulo 2^CNTW.
  always_ff @(posedge i_clk) begin
    if (i_rst)           r_issueCount <= '0;
    else if (w_transfer) r_issueCount <= r_issueCount + 1'b1;
  end

  // Outputs driven straight from the state and operand registers.
  always_comb begin
    o_m_valid     = (r_state == OUT_HOLD);
    o_m_a         = r_mA;
    o_m_b         = r_mB;
    o_issue_count = r_issueCount;
  end

endmodule

// File: tb/tb_mult_operand_feeder.sv
// tb_mult_operand_feeder
// Directed bench for mult_operand_feeder, with a behavioural repeated-addition
// multiplier for the end-to-end run and a narrow-counter instance for the
// issue_count wrap.
module tb_mult_operand_feeder;

  logic        clk = 1'b0;
  logic        rst;
  logic        sValid;
  logic        sReady;
  logic [3:0]  sA;
  logic [3:0]  sB;
  logic        mValid;
  logic        mReady;
  logic [3:0]  mA;
  logic [3:0]  mB;
  logic [2:0]  fillLevel;
  logic [15:0] issueCount;
  logic        tbReady;
  bit          useMult;

  logic        s2Valid;
  logic        s2Ready;
  logic        m2Valid;
  logic        m2Ready;
  logic [3:0]  mA2;
  logic [3:0]  mB2;
  logic [2:0]  fill2;
  logic [2:0]  issue2;

  logic        multBusy;
  logic [7:0]  multAcc;
  logic [3:0]  multA;
  logic [3:0]  multCnt;
  int          resultQ[$];

  int total = 0;
  int bad = 0;
  int expIssue = 0;

  always #5 clk = ~clk;

  assign mReady = useMult ? !multBusy : tbReady;

  mult_operand_feeder #(.OPW(4), .DEPTH(4), .CNTW(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_s_valid(sValid), .o_s_ready(sReady),
    .i_s_a(sA), .i_s_b(sB), .o_m_valid(mValid), .i_m_ready(mReady),
    .o_m_a(mA), .o_m_b(mB), .o_fill_level(fillLevel), .o_issue_count(issueCount)
  );

  mult_operand_feeder #(.OPW(4), .DEPTH(4), .CNTW(3)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_s_valid(s2Valid), .o_s_ready(s2Ready),
    .i_s_a(4'd1), .i_s_b(4'd1), .o_m_valid(m2Valid), .i_m_ready(m2Ready),
    .o_m_a(mA2), .o_m_b(mB2), .o_fill_level(fill2), .o_issue_count(issue2)
  );

  // Behavioural multiplier: accepts when idle, adds a b times, then re-asserts ready.
  always @(posedge clk) begin
    if (rst) begin
      multBusy <= 1'b0;
      multAcc  <= '0;
      multA    <= '0;
      multCnt  <= '0;
    end else if (useMult) begin
      if (!multBusy) begin
        if (mValid) begin
          multBusy <= 1'b1;
          multAcc  <= '0;
          multA    <= mA;
          multCnt  <= mB;
        end
      end else if (multCnt == 4'd0) begin
        resultQ.push_back(int'(multAcc));
        multBusy <= 1'b0;
      end else begin
        multAcc <= multAcc + {4'd0, multA};
        multCnt <= multCnt - 4'd1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; sValid = 1'b0; sA = '0; sB = '0; tbReady = 1'b0; useMult = 1'b0;
    s2Valid = 1'b0; m2Ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    total++; if (mValid !== 1'b0) begin bad++; $display("[TB] FAIL reset_mvalid got=%0b exp=0", mValid); end
    total++; if (fillLevel !== 3'd0) begin bad++; $display("[TB] FAIL reset_fill got=%0d exp=0", fillLevel); end
    total++; if (issueCount !== 16'd0) begin bad++; $display("[TB] FAIL reset_issue got=%0d exp=0", issueCount); end
    total++; if (sReady !== 1'b1) begin bad++; $display("[TB] FAIL reset_sready got=%0b exp=1", sReady); end
    total++; if ({mA, mB} !== 8'h00) begin bad++; $display("[TB] FAIL reset_mab got=%0h exp=00", {mA, mB}); end
  endtask

  task automatic test_single_op();
    tbReady = 1'b1;
    sValid = 1'b1; sA = 4'd3; sB = 4'd5;
    tick();
    sValid = 1'b0;
    total++; if (fillLevel !== 3'd1) begin bad++; $display("[TB] FAIL single_fill got=%0d exp=1", fillLevel); end
    total++; if (mValid !== 1'b0) begin bad++; $display("[TB] FAIL single_early_valid got=%0b exp=0", mValid); end
    tick();
    total++; if (mValid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%0b exp=1", mValid); end
    total++; if ({mA, mB} !== 8'h35) begin bad++; $display("[TB] FAIL single_mab got=%0h exp=35", {mA, mB}); end
    total++; if (fillLevel !== 3'd0) begin bad++; $display("[TB] FAIL single_fill_pop got=%0d exp=0", fillLevel); end
    tick();
    expIssue = 1;
    total++; if (mValid !== 1'b0) begin bad++; $display("[TB] FAIL single_done_valid got=%0b exp=0", mValid); end
    total++; if (issueCount !== 16'd1) begin bad++; $display("[TB] FAIL single_issue got=%0d exp=1", issueCount); end
    tbReady = 1'b0;
  endtask

  task automatic test_zero_sub();
    tbReady = 1'b0;
    sValid = 1'b1; sA = 4'd7; sB = 4'd0;
    tick();
    sValid = 1'b0;
    tick();
    total++; if (mValid !== 1'b1) begin bad++; $display("[TB] FAIL zero_valid got=%0b exp=1", mValid); end
    total++; if ({mA, mB} !== 8'h01) begin bad++; $display("[TB] FAIL zero_sub got=%0h exp=01", {mA, mB}); end
    sValid = 1'b1; sA = 4'd0; sB = 4'd6;
    tick();
    sValid = 1'b0;
    tick(); tick();
    total++; if ({mValid, mA, mB} !== 9'h101) begin bad++; $display("[TB] FAIL zero_hold got=%0h exp=101", {mValid, mA, mB}); end
    total++; if (fillLevel !== 3'd1) begin bad++; $display("[TB] FAIL zero_fill got=%0d exp=1", fillLevel); end
    total++; if (issueCount !== 16'd1) begin bad++; $display("[TB] FAIL zero_hold_issue got=%0d exp=1", issueCount); end
    tbReady = 1'b1;
    tick();
    total++; if ({mValid, mA, mB} !== 9'h106) begin bad++; $display("[TB] FAIL zero_a0_pass got=%0h exp=106", {mValid, mA, mB}); end
    total++; if (issueCount !== 16'd2) begin bad++; $display("[TB] FAIL zero_issue2 got=%0d exp=2", issueCount); end
    tick();
    expIssue = 3;
    total++; if (mValid !== 1'b0) begin bad++; $display("[TB] FAIL zero_drain got=%0b exp=0", mValid); end
    total++; if (issueCount !== 16'd3) begin bad++; $display("[TB] FAIL zero_issue3 got=%0d exp=3", issueCount); end
    tbReady = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [6];
    logic [7:0] got [6];
    int n;
    logic pushNow;
    exp[0] = 8'h12; exp[1] = 8'h23; exp[2] = 8'h34;
    exp[3] = 8'h45; exp[4] = 8'h56; exp[5] = 8'h67;
    for (int i = 0; i < 6; i++) got[i] = 8'h00;
    tbReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sValid = 1'b1; {sA, sB} = exp[i];
      tick();
    end
    {sA, sB} = exp[5];
    tick(); tick();
    total++; if (fillLevel !== 3'd4) begin bad++; $display("[TB] FAIL bp_fill got=%0d exp=4", fillLevel); end
    total++; if (sReady !== 1'b0) begin bad++; $display("[TB] FAIL bp_sready got=%0b exp=0", sReady); end
    total++; if ({mValid, mA, mB} !== 9'h112) begin bad++; $display("[TB] FAIL bp_head got=%0h exp=112", {mValid, mA, mB}); end
    tbReady = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (mValid) begin
        if (n < 6) got[n] = {mA, mB};
        n++;
      end
      pushNow = sValid && sReady;
      tick();
      if (c == 0) begin
        total++; if (fillLevel !== 3'd3) begin bad++; $display("[TB] FAIL fullpop_fill got=%0d exp=3", fillLevel); end
        total++; if (sReady !== 1'b1) begin bad++; $display("[TB] FAIL fullpop_sready got=%0b exp=1", sReady); end
      end
      if (pushNow) sValid = 1'b0;
    end
    total++; if (n != 6) begin bad++; $display("[TB] FAIL bp_count got=%0d exp=6", n); end
    for (int i = 0; i < 6; i++) begin
      total++; if (got[i] !== exp[i]) begin bad++; $display("[TB] FAIL bp_order[%0d] got=%0h exp=%0h", i, got[i], exp[i]); end
    end
    expIssue = expIssue + 6;
    total++; if (issueCount !== 16'(expIssue)) begin bad++; $display("[TB] FAIL bp_issue got=%0d exp=%0d", issueCount, expIssue); end
    total++; if (mValid !== 1'b0) begin bad++; $display("[TB] FAIL bp_drain got=%0b exp=0", mValid); end
    sValid = 1'b0;
    tbReady = 1'b0;
  endtask

  task automatic test_reset_mid();
    tbReady = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      sValid = 1'b1; sA = 4'(i); sB = 4'(i);
      tick();
    end
    sValid = 1'b0;
    total++; if ({mValid, fillLevel} !== 4'b1011) begin bad++; $display("[TB] FAIL mid_pre got=%0b exp=1011", {mValid, fillLevel}); end
    rst = 1'b1; sValid = 1'b1; sA = 4'd5; sB = 4'd5; tbReady = 1'b1;
    tick();
    rst = 1'b0; sValid = 1'b0; tbReady = 1'b0;
    total++; if (mValid !== 1'b0) begin bad++; $display("[TB] FAIL mid_valid got=%0b exp=0", mValid); end
    total++; if (fillLevel !== 3'd0) begin bad++; $display("[TB] FAIL mid_fill got=%0d exp=0", fillLevel); end
    total++; if (issueCount !== 16'd0) begin bad++; $display("[TB] FAIL mid_issue got=%0d exp=0", issueCount); end
    total++; if (sReady !== 1'b1) begin bad++; $display("[TB] FAIL mid_sready got=%0b exp=1", sReady); end
    tbReady = 1'b1;
    sValid = 1'b1; sA = 4'd2; sB = 4'd9;
    tick();
    sValid = 1'b0;
    tick();
    total++; if ({mValid, mA, mB} !== 9'h129) begin bad++; $display("[TB] FAIL mid_after got=%0h exp=129", {mValid, mA, mB}); end
    tick();
    expIssue = 1;
    total++; if (issueCount !== 16'd1) begin bad++; $display("[TB] FAIL mid_after_issue got=%0d exp=1", issueCount); end
    tbReady = 1'b0;
  endtask

  task automatic test_end_to_end();
    int expQ[$];
    bit accepted;
    bit timedOut;
    logic [3:0] a;
    logic [3:0] b;
    resultQ.delete();
    useMult = 1'b1;
    timedOut = 1'b0;
    for (int i = 0; i < 200 && !timedOut; i++) begin
      a = ($urandom_range(0, 5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      b = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      expQ.push_back(int'(a) * int'(b));
      sValid = 1'b1; sA = a; sB = b;
      accepted = 1'b0;
      for (int w = 0; w < 100 && !accepted; w++) begin
        accepted = sReady;
        tick();
      end
      if (!accepted) begin
        timedOut = 1'b1;
        total++; bad++;
        $display("[TB] FAIL e2e_push_timeout got=stalled exp=accepted pair %0d", i);
      end
    end
    sValid = 1'b0;
    for (int w = 0; w < 5000 && resultQ.size() < expQ.size(); w++) tick();
    total++; if (resultQ.size() != expQ.size()) begin bad++; $display("[TB] FAIL e2e_count got=%0d exp=%0d", resultQ.size(), expQ.size()); end
    for (int i = 0; i < expQ.size() && i < resultQ.size(); i++) begin
      total++; if (resultQ[i] != expQ[i]) begin bad++; $display("[TB] FAIL e2e_product[%0d] got=%0d exp=%0d", i, resultQ[i], expQ[i]); end
    end
    expIssue = expIssue + expQ.size();
    total++; if (issueCount !== 16'(expIssue)) begin bad++; $display("[TB] FAIL e2e_issue got=%0d exp=%0d", issueCount, expIssue); end
    useMult = 1'b0;
  endtask

  task automatic test_issue_wrap();
    m2Ready = 1'b1;
    s2Valid = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    s2Valid = 1'b0;
    tick();
    total++; if (issue2 !== 3'd7) begin bad++; $display("[TB] FAIL wrap_pre got=%0d exp=7", issue2); end
    total++; if (s2Ready !== 1'b1) begin bad++; $display("[TB] FAIL wrap_sready got=%0b exp=1", s2Ready); end
    tick();
    total++; if (issue2 !== 3'd0) begin bad++; $display("[TB] FAIL wrap_zero got=%0d exp=0", issue2); end
    total++; if ({m2Valid, fill2} !== 4'b0000) begin bad++; $display("[TB] FAIL wrap_idle got=%0b exp=0000", {m2Valid, fill2}); end
    total++; if ({mA2, mB2} !== 8'h11) begin bad++; $display("[TB] FAIL wrap_last got=%0h exp=11", {mA2, mB2}); end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_zero_sub();
    test_backpressure();
    test_reset_mid();
    test_end_to_end();
    test_issue_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
